// File: rtl/dsp_result_collector.sv
// dsp_result_collector
//   Downstream stage of the registered-input RS_DSP multiply wrapper. Each 38-bit z result
//   is tagged with a delayed copy of the operand-issue valid/shift. The result is then
//   right-shifted and saturated to OUT_W, buffered in a FIFO, and presented on a
//   ready/valid stream with a per-frame last flag. The DSP cannot stall, so upstream
//   operand issue is paced by credits on in_ready.
//
//   Optional feature: define DSP_RESULT_ROUND_EN to round half up before shifting.
//   Without it, results are truncated.
//
// Ports
//   clock0      single clock, rising edge
//   reset       synchronous, active-high
//   in_valid    operands issued to the DSP this cycle (legal only while in_ready=1)
//   in_shift    right-shift amount travelling with in_valid
//   in_ready    credit available for another operand issue
//   z_in        DSP z output, unsigned, LAT cycles after issue
//   out_data    shifted, saturated result
//   out_valid   out_data valid
//   out_ready   consumer accepts when out_valid & out_ready
//   out_last    final word of the current frame
//   out_sat     out_data was saturated
//   fifo_count  FIFO occupancy (excludes the output register)
//   overflow    sticky: a tagged result arrived while the FIFO was full
module dsp_result_collector #(
    parameter int unsigned LAT       = 1,
    parameter int unsigned OUT_W     = 24,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                   clock0,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [5:0]             in_shift,
    output logic                   in_ready,
    input  logic [37:0]            z_in,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   out_sat,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned EntW = OUT_W + 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);
    localparam logic [15:0] LastIdx = 16'(FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // Issue delay line: stage LAT-1 lines up with z_in.
    // ------------------------------------------------------------------
    logic [LAT-1:0] dl_v_q;
    logic [5:0]     dl_shift_q [LAT];
    logic           tag_v;
    logic [5:0]     tag_shift;
    logic [3:0]     inflight;

    always_ff @(posedge clock0) begin
        if (reset) begin
            dl_v_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_shift_q[i] <= '0;
            end
        end else begin
            dl_v_q[0]     <= in_valid;
            dl_shift_q[0] <= in_shift;
            for (int i = 1; i < LAT; i++) begin
                dl_v_q[i]     <= dl_v_q[i-1];
                dl_shift_q[i] <= dl_shift_q[i-1];
            end
        end
    end

    assign tag_v     = dl_v_q[LAT-1];
    assign tag_shift = dl_shift_q[LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {3'd0, dl_v_q[i]};
        end
    end

    // ------------------------------------------------------------------
    // Shift and saturate.
    // ------------------------------------------------------------------
    logic [37:0]      shifted;
    logic             carry;
    logic             over_hi;
    logic             word_sat;
    logic [OUT_W-1:0] word;

`ifdef DSP_RESULT_ROUND_EN
    logic [38:0] rnd_sum;

    always_comb begin
        rnd_sum = {1'b0, z_in};
        if (tag_shift != 6'd0) begin
            rnd_sum = rnd_sum + (39'd1 << (tag_shift - 6'd1));
        end
        shifted = 38'(rnd_sum >> tag_shift);
        // A carry out of the 38-bit range cannot be represented: treat as saturation.
        carry   = rnd_sum[38];
    end
`else
    always_comb begin
        // Shift amounts of 38..63 shift everything out and give zero.
        shifted = z_in >> tag_shift;
        carry   = 1'b0;
    end
`endif

    if (OUT_W < 38) begin : g_sat
        assign over_hi = |shifted[37:OUT_W];
    end else begin : g_nosat
        assign over_hi = 1'b0;
    end

    assign word_sat = over_hi | carry;
    assign word     = word_sat ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

    // ------------------------------------------------------------------
    // Result FIFO.
    // ------------------------------------------------------------------
    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            drop;
    logic [EntW-1:0] head;

    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push       = tag_v & (~fifo_full | pop);
    assign drop       = tag_v & fifo_full & ~pop;
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clock0) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {word, word_sat};
        end
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign fifo_count = count_q;

    // The output register is a storage slot of its own, so leaving it out of the
    // credit sum gives DEPTH+1 results of capacity with no overflow possible.
    assign in_ready = (32'(count_q) + 32'(inflight)) < DEPTH;

    // ------------------------------------------------------------------
    // Output FSM.
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {StEmpty, StHold} state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (!fifo_empty) state_d = StHold;
            StHold:  if (out_ready && fifo_empty) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StEmpty: pop = ~fifo_empty;
            StHold: begin
                out_valid = 1'b1;
                pop       = out_ready & ~fifo_empty;
            end
            default: begin
                pop       = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Every pop loads the head into the output register; nothing else changes it.
    always_ff @(posedge clock0) begin
        if (reset) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (pop) begin
            out_data <= head[EntW-1:1];
            out_sat  <= head[0];
        end
    end

    // ------------------------------------------------------------------
    // Frame counter.
    // ------------------------------------------------------------------
    logic [15:0] frame_q;
    logic        accept;

    assign accept = out_valid & out_ready;

    always_ff @(posedge clock0) begin
        if (reset) begin
            frame_q <= '0;
        end else if (accept) begin
            frame_q <= (frame_q == LastIdx) ? 16'd0 : frame_q + 16'd1;
        end
    end

    assign out_last = out_valid & (frame_q == LastIdx);

endmodule
